// File: rtl/nanosoc_ahb_pkg.sv
// Shared AHB-Lite encodings for nanosoc bus masters and slaves.
// Transfer types, responses, sizes and the fixed burst/protection attributes.
package nanosoc_ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_t;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   // Any response other than OKAY is treated as an error by initiators.
   function automatic logic resp_is_okay(input logic [1:0] resp);
      return resp == HRESP_OKAY;
   endfunction

endpackage

// File: rtl/nanosoc_ahb_cmd_master.sv
// Single-transfer AHB-Lite initiator: valid/ready commands become NONSEQ SINGLE
// transfers with overlapped address/data phases; one response per command.
module nanosoc_ahb_cmd_master
   import nanosoc_ahb_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_write,
   input  logic [2:0]        cmd_size,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_error,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [3:0]        HPROT,
   output logic              HMASTLOCK,
   output logic [31:0]       HWDATA,
   input  logic [31:0]       HRDATA,
   input  logic              HREADY,
   input  logic [1:0]        HRESP
);

   logic              vld_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic              write_p0;
   logic [2:0]        size_p0;
   logic [31:0]       wdata_p0;
   logic              vld_p1;
   logic              write_p1;
   logic              err_hold;
   logic              err_first;
   logic              accept;
   logic              resp_okay;
   logic [31:0]       hwdata_p1;

   assign resp_okay = resp_is_okay(HRESP);
   assign err_first = vld_p1 & ~HREADY & ~resp_okay;
   assign cmd_ready = ~err_hold & ~err_first & (~vld_p0 | HREADY);
   assign accept    = cmd_valid & cmd_ready;

   assign HADDR     = addr_p0;
   assign HWRITE    = write_p0;
   assign HSIZE     = size_p0;
   assign HTRANS    = (vld_p0 && !err_hold) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HWDATA    = hwdata_p1;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_DEFAULT;
   assign HMASTLOCK = 1'b0;

   // Address phase (p0). Write data carries no reset; it only matters once
   // the transfer has advanced into the data phase.
   always_ff @(posedge HCLK) begin
      if (accept) begin
         wdata_p0 <= cmd_wdata;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         vld_p0    <= 1'b0;
         addr_p0   <= '0;
         write_p0  <= 1'b0;
         size_p0   <= '0;
         vld_p1    <= 1'b0;
         write_p1  <= 1'b0;
         hwdata_p1 <= '0;
         err_hold  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         // An empty AP may be filled during a wait state: HTRANS was IDLE,
         // so presenting a new address then is legal and no command is lost.
         if (accept) begin
            vld_p0   <= 1'b1;
            addr_p0  <= cmd_addr;
            write_p0 <= cmd_write;
            size_p0  <= cmd_size;
         end else if (HREADY && !err_hold) begin
            vld_p0 <= 1'b0;
         end
         // Data phase (p1) and response stage.
         if (HREADY) begin
            vld_p1   <= vld_p0 & ~err_hold;
            write_p1 <= write_p0;
            err_hold <= 1'b0;
            if (vld_p0 && !err_hold) begin
               hwdata_p1 <= wdata_p0;
            end
            if (vld_p1) begin
               rsp_valid <= 1'b1;
               rsp_error <= ~resp_okay;
               rsp_rdata <= (!write_p1 && resp_okay) ? HRDATA : 32'd0;
            end
         end else if (err_first) begin
            err_hold <= 1'b1;
         end
      end
   end

endmodule
